n64_pi_address_tracker: RTL and testbench

Front end of the cartridge PI (parallel interface) path, directly upstream of the cartridge address decoder. It tracks the multiplexed 16-bit N64 PI bus and assembles the 32-bit bus address from the ALE_H/ALE_L phases. It auto-increments that address across burst strobes and presents it as `o_address` to the decoder. It uses the decoder's `o_address_valid` result to gate read prefetches, write requests and AD output drive, and it converts PI read/write strobes into single-cycle request pulses toward the internal bus.

---
 rtl/n64_pi_address_tracker.sv | 174 +++++++++++++++++
 tb/tb_n64_pi_address_tracker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_pi_address_tracker.sv
// PI bus front end: assembles the 32-bit address from the ALE_H/ALE_L phases, steps it across
// burst strobes and turns PI read/write strobes into single-cycle internal bus requests.
module n64_pi_address_tracker (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_n64_pi_aleh,
  input  logic        i_n64_pi_alel,
  input  logic        i_n64_pi_read,
  input  logic        i_n64_pi_write,
  input  logic [15:0] i_n64_pi_ad,
  output logic [15:0] o_n64_pi_ad,
  output logic        o_n64_pi_ad_oe,
  output logic [31:0] o_address,
  input  logic        i_address_valid,
  output logic        o_read_request,
  input  logic        i_read_ack,
  input  logic [15:0] i_read_data,
  output logic        o_write_request,
  output logic [31:0] o_write_address,
  output logic [15:0] o_write_data,
  output logic        o_read_underrun
);

  typedef enum logic [1:0] {StIdle, StAddrH, StAddrL, StData} state_e;

  state_e      state_q;
  logic        aleh_prev_q, alel_prev_q, read_prev_q, write_prev_q;
  logic [31:0] address_q;
  logic [15:0] ad_q;
  logic        oe_q;
  logic        read_req_q, write_req_q;
  logic [31:0] write_addr_q;
  logic [15:0] write_data_q;
  logic        underrun_q;
  logic        pending_q, discard_q, active_q;
  logic        sample_q;  // first DATA cycle: decoder verdict is sampled here
  logic        want_q;    // a prefetch is owed once the outstanding read clears
  logic [15:0] buffer_q;

  logic        aleh_rise, aleh_fall, alel_fall;
  logic        read_fall, read_rise, write_fall, write_rise, write_edge;
  logic        in_data, rd_fall_ok, rd_rise_ok, wr_rise_ok;
  logic        ack_hit, pending_eff, want_c, issue;
  logic [31:0] address_inc;

  always_comb begin
    aleh_rise   = ~aleh_prev_q & i_n64_pi_aleh;
    aleh_fall   = aleh_prev_q & ~i_n64_pi_aleh;
    alel_fall   = alel_prev_q & ~i_n64_pi_alel;
    read_fall   = read_prev_q & ~i_n64_pi_read;
    read_rise   = ~read_prev_q & i_n64_pi_read;
    write_fall  = write_prev_q & ~i_n64_pi_write;
    write_rise  = ~write_prev_q & i_n64_pi_write;
    write_edge  = write_fall | write_rise;
    // An ALE_H rise aborts the burst, so strobes in that cycle are dropped.
    in_data     = (state_q == StData) & ~aleh_rise;
    rd_fall_ok  = in_data & read_fall & ~write_edge;
    rd_rise_ok  = in_data & read_rise & ~write_edge;
    wr_rise_ok  = in_data & write_rise;
    ack_hit     = i_read_ack & pending_q;
    // The clearing ack lets the next prefetch go out in the same cycle.
    pending_eff = pending_q & ~i_read_ack;
    want_c      = want_q | (rd_rise_ok & active_q);
    issue       = in_data & ~wr_rise_ok & ~pending_eff &
                  (sample_q ? i_address_valid : (active_q & want_c));
    address_inc = address_q + 32'd2;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      aleh_prev_q  <= 1'b0;
      alel_prev_q  <= 1'b0;
      read_prev_q  <= 1'b1;
      write_prev_q <= 1'b1;
      address_q    <= '0;
      ad_q         <= '0;
      oe_q         <= 1'b0;
      read_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      underrun_q   <= 1'b0;
      pending_q    <= 1'b0;
      discard_q    <= 1'b0;
      active_q     <= 1'b0;
      sample_q     <= 1'b0;
      want_q       <= 1'b0;
      buffer_q     <= '0;
    end else begin
      aleh_prev_q  <= i_n64_pi_aleh;
      alel_prev_q  <= i_n64_pi_alel;
      read_prev_q  <= i_n64_pi_read;
      write_prev_q <= i_n64_pi_write;
      read_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      ad_q         <= buffer_q;

      if (ack_hit) begin
        pending_q <= 1'b0;
        discard_q <= 1'b0;
        if (!discard_q) begin
          buffer_q <= i_read_data;
        end
      end

      if (aleh_rise) begin
        state_q   <= StAddrH;
        oe_q      <= 1'b0;
        active_q  <= 1'b0;
        sample_q  <= 1'b0;
        want_q    <= 1'b0;
        discard_q <= pending_eff;
      end else begin
        case (state_q)
          StIdle: begin
            if (i_n64_pi_aleh && i_n64_pi_alel) begin
              state_q <= StAddrH;
            end
          end
          StAddrH: begin
            if (aleh_fall) begin
              address_q[31:16] <= i_n64_pi_ad;
              state_q          <= StAddrL;
            end
          end
          StAddrL: begin
            if (alel_fall) begin
              address_q[15:0] <= {i_n64_pi_ad[15:1], 1'b0};
              state_q         <= StData;
              sample_q        <= 1'b1;
            end
          end
          StData: begin
            oe_q <= active_q & ~i_n64_pi_read;
            if (sample_q) begin
              sample_q <= 1'b0;
              active_q <= i_address_valid;
              want_q   <= i_address_valid & ~issue;
            end else begin
              want_q <= want_c & ~issue & ~wr_rise_ok;
            end
            if (wr_rise_ok) begin
              write_data_q <= i_n64_pi_ad;
              write_addr_q <= address_q;
              write_req_q  <= active_q;
              address_q    <= address_inc;
            end else if (rd_rise_ok) begin
              address_q <= address_inc;
            end
            if (rd_fall_ok && pending_q && active_q) begin
              underrun_q <= 1'b1;
            end
            if (issue) begin
              read_req_q <= 1'b1;
              pending_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_n64_pi_ad     = ad_q;
  assign o_n64_pi_ad_oe  = oe_q;
  assign o_address       = address_q;
  assign o_read_request  = read_req_q;
  assign o_write_request = write_req_q;
  assign o_write_address = write_addr_q;
  assign o_write_data    = write_data_q;
  assign o_read_underrun = underrun_q;

endmodule

// File: tb/tb_n64_pi_address_tracker.sv
// Scoreboard bench for n64_pi_address_tracker: directed PI bursts push expected requests and
// AD values into queues that a negedge monitor pops as the DUT presents them.
module tb_n64_pi_address_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aleh = 1'b0, alel = 1'b0, rd = 1'b1, wr = 1'b1;
  logic [15:0] ad_in = '0;
  logic [15:0] o_ad;
  logic        o_oe;
  logic [31:0] o_address;
  logic        addr_valid;
  logic        o_read_request;
  logic        read_ack = 1'b0;
  logic [15:0] read_data = '0;
  logic        o_write_request;
  logic [31:0] o_write_address;
  logic [15:0] o_write_data;
  logic        o_read_underrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rd_q[$];
  logic [47:0] exp_wr_q[$];
  logic [15:0] exp_ad_q[$];
  logic [15:0] ack_data_q[$];

  int          ack_delay = 1;
  int          ack_timer = -1;
  logic        oe_prev = 1'b0;
  logic [15:0] ad_last = '0;

  always #5 clk = ~clk;

  // Decoder stand-in: cartridge window 0x1xxx_xxxx plus the top 0xFxxx_xxxx region.
  assign addr_valid = (o_address[31:28] == 4'h1) || (o_address[31:28] == 4'hF);

  n64_pi_address_tracker dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_n64_pi_aleh   (aleh),
    .i_n64_pi_alel   (alel),
    .i_n64_pi_read   (rd),
    .i_n64_pi_write  (wr),
    .i_n64_pi_ad     (ad_in),
    .o_n64_pi_ad     (o_ad),
    .o_n64_pi_ad_oe  (o_oe),
    .o_address       (o_address),
    .i_address_valid (addr_valid),
    .o_read_request  (o_read_request),
    .i_read_ack      (read_ack),
    .i_read_data     (read_data),
    .o_write_request (o_write_request),
    .o_write_address (o_write_address),
    .o_write_data    (o_write_data),
    .o_read_underrun (o_read_underrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks each request ack_delay cycles later with the next queued halfword.
  always @(negedge clk) begin
    read_ack = 1'b0;
    if (o_read_request === 1'b1) ack_timer = ack_delay;
    if (ack_timer == 0) begin
      read_ack  = 1'b1;
      read_data = (ack_data_q.size() > 0) ? ack_data_q.pop_front() : 16'h0000;
      ack_timer = -1;
    end else if (ack_timer > 0) begin
      ack_timer--;
    end
  end

  // Monitor: request pulses and the AD value last driven before each oe drop.
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_prev = 1'b0;
    end else begin
      if (o_read_request === 1'b1) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_request_unexpected: got address 0x%0h, expected no request",
                   o_address);
        end else begin
          check("read_request_address", {32'h0, o_address}, {32'h0, exp_rd_q.pop_front()});
        end
      end
      if (o_write_request === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_request_unexpected: got 0x%0h/0x%0h, expected no request",
                   o_write_address, o_write_data);
        end else begin
          check("write_request_addr_data", {16'h0, o_write_address, o_write_data},
                {16'h0, exp_wr_q.pop_front()});
        end
      end
      if (oe_prev && !o_oe) begin
        if (exp_ad_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ad_drive_unexpected: got oe with AD 0x%0h, expected no drive", ad_last);
        end else begin
          check("ad_drive", {48'h0, ad_last}, {48'h0, exp_ad_q.pop_front()});
        end
      end
      if (o_oe === 1'b1) ad_last = o_ad;
      oe_prev = (o_oe === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ale_phase(input logic [31:0] addr, input int post);
    aleh = 1'b1;
    alel = 1'b1;
    tick(2);
    ad_in = addr[31:16];
    aleh  = 1'b0;
    tick(2);
    ad_in = addr[15:0];
    alel  = 1'b0;
    tick(post);
  endtask

  task automatic read_strobe(input int low);
    rd = 1'b0;
    tick(low);
    rd = 1'b1;
    tick(4);
  endtask

  task automatic write_strobe(input logic [15:0] data);
    ad_in = data;
    wr    = 1'b0;
    tick(2);
    wr = 1'b1;
    tick(3);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_address"}, {32'h0, o_address}, 64'h0);
    check({tag, "_ad"}, {48'h0, o_ad}, 64'h0);
    check({tag, "_oe"}, {63'h0, o_oe}, 64'h0);
    check({tag, "_read_request"}, {63'h0, o_read_request}, 64'h0);
    check({tag, "_write_request"}, {63'h0, o_write_request}, 64'h0);
    check({tag, "_write_address"}, {32'h0, o_write_address}, 64'h0);
    check({tag, "_write_data"}, {48'h0, o_write_data}, 64'h0);
    check({tag, "_underrun"}, {63'h0, o_read_underrun}, 64'h0);
  endtask

  initial begin
    tick(3);
    check_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // Read burst: prefetch, then one prefetch per read rise.
    exp_rd_q.push_back(32'h1000_0040);
    exp_rd_q.push_back(32'h1000_0042);
    exp_rd_q.push_back(32'h1000_0044);
    ack_data_q.push_back(16'hA55A);
    ack_data_q.push_back(16'h1234);
    ack_data_q.push_back(16'h5555);
    exp_ad_q.push_back(16'hA55A);
    exp_ad_q.push_back(16'h1234);
    ale_phase(32'h1000_0040, 6);
    check("read_burst_latched_address", {32'h0, o_address}, 64'h1000_0040);
    read_strobe(4);
    check("read_burst_address_1", {32'h0, o_address}, 64'h1000_0042);
    read_strobe(4);
    check("read_burst_address_2", {32'h0, o_address}, 64'h1000_0044);

    // Write burst: only the entry prefetch reads.
    exp_rd_q.push_back(32'h1D00_0000);
    ack_data_q.push_back(16'h0101);
    exp_wr_q.push_back({32'h1D00_0000, 16'hBEEF});
    exp_wr_q.push_back({32'h1D00_0002, 16'hCAFE});
    ale_phase(32'h1D00_0000, 6);
    write_strobe(16'hBEEF);
    write_strobe(16'hCAFE);
    check("write_burst_end_address", {32'h0, o_address}, 64'h1D00_0004);

    // Invalid address: nothing requested or driven, address still steps.
    ale_phase(32'h0500_0000, 6);
    read_strobe(3);
    write_strobe(16'h1111);
    check("invalid_end_address", {32'h0, o_address}, 64'h0500_0004);
    check("no_underrun_yet", {63'h0, o_read_underrun}, 64'h0);

    // Underrun: first read falls while the prefetch is held off.
    ack_delay = 10;
    exp_rd_q.push_back(32'h1000_0100);
    exp_rd_q.push_back(32'h1000_0102);
    exp_rd_q.push_back(32'h1000_0104);
    ack_data_q.push_back(16'h4242);
    ack_data_q.push_back(16'h9999);
    ack_data_q.push_back(16'h3333);
    exp_ad_q.push_back(16'h0101);
    exp_ad_q.push_back(16'h4242);
    ale_phase(32'h1000_0100, 3);
    read_strobe(3);
    check("underrun_flag", {63'h0, o_read_underrun}, 64'h1);
    tick(4);
    read_strobe(3);
    tick(16);
    ack_delay = 1;

    // Abort with a read outstanding: 0xDEAD is discarded, new burst gets its own data.
    ack_delay = 12;
    exp_rd_q.push_back(32'h1000_0200);
    exp_rd_q.push_back(32'h1E00_0010);
    exp_rd_q.push_back(32'h1E00_0012);
    exp_rd_q.push_back(32'h1E00_0014);
    ack_data_q.push_back(16'hDEAD);
    ack_data_q.push_back(16'h7777);
    ack_data_q.push_back(16'h8888);
    ack_data_q.push_back(16'h4444);
    exp_ad_q.push_back(16'h3333);
    exp_ad_q.push_back(16'h7777);
    ale_phase(32'h1000_0200, 6);
    ale_phase(32'h1E00_0010, 6);
    read_strobe(3);
    tick(6);
    read_strobe(3);
    ack_delay = 1;
    tick(10);
    check("abort_end_address", {32'h0, o_address}, 64'h1E00_0014);

    // Reset mid-read; the late ack must be ignored.
    ack_delay = 4;
    exp_rd_q.push_back(32'h1000_0300);
    ack_data_q.push_back(16'h5A5A);
    ale_phase(32'h1000_0300, 2);
    rd = 1'b0;
    tick(1);
    rst_n = 1'b0;
    rd    = 1'b1;
    tick(2);
    check_reset("midburst_reset");
    rst_n     = 1'b1;
    ack_delay = 1;

    // Wrap: 0xFFFF_FFFE steps to 0 after one strobe.
    exp_rd_q.push_back(32'hFFFF_FFFE);
    exp_rd_q.push_back(32'h0000_0000);
    ack_data_q.push_back(16'h6161);
    ack_data_q.push_back(16'h6262);
    exp_ad_q.push_back(16'h6161);
    ale_phase(32'hFFFF_FFFE, 6);
    check("wrap_latched_address", {32'h0, o_address}, 64'hFFFF_FFFE);
    read_strobe(3);
    check("wrap_address", {32'h0, o_address}, 64'h0000_0000);

    tick(10);
    check("read_requests_all_seen", 64'(exp_rd_q.size()), 64'h0);
    check("write_requests_all_seen", 64'(exp_wr_q.size()), 64'h0);
    check("ad_drives_all_seen", 64'(exp_ad_q.size()), 64'h0);
    check("acks_all_consumed", 64'(ack_data_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
